// File: rtl/uart_sram_loader.sv
// uart_sram_loader: receives a framed UART byte stream (sync 0xA5, length,
// payload, XOR checksum) and writes the payload sequentially into an
// asynchronous SRAM. Reports a sticky done or a sticky err.
module uart_sram_loader #(
    parameter int CLKS_PER_BIT = 52,
    parameter int ADDR_W       = 17,
    parameter int PARITY       = 0,
    parameter int WE_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    inout  wire  [7:0]        data_io,
    output logic              nce,
    output logic              noe,
    output logic              nwe,
    output logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic              err
);

    localparam int NB  = (ADDR_W + 7) / 8;
    localparam int LW  = 8 * NB;
    localparam int WCW = $clog2(WE_CYCLES + 1);
    localparam logic [LW:0] MAX_LEN = (LW + 1)'(1) << ADDR_W;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
    typedef enum logic [2:0] {F_SYNC, F_LEN, F_DATA, F_CSUM, F_DONE, F_ERR} frame_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_t;

    rx_state_t    rx_state;
    frame_state_t f_state;
    wr_state_t    wr_state;

    logic          rx_s1, rx_s2, rx_d;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          exp_par;
    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          rx_ferr, rx_perr;

    logic [3:0]    len_idx;
    logic [LW-1:0] length;
    logic [LW-1:0] len_next;
    logic [LW-1:0] remaining;
    logic [7:0]    csum;
    logic [7:0]    wdata;
    logic          drive;
    logic [WCW-1:0] wcnt;
    logic          busy;
    logic          terminal;

    assign exp_par  = (^shift) ^ (PARITY == 2);
    assign len_next = length | (LW'(rx_byte) << (8 * len_idx));
    assign busy     = (wr_state != W_IDLE);
    assign terminal = (f_state == F_DONE) || (f_state == F_ERR);
    assign data_io  = drive ? wdata : 8'bz;
    assign noe      = 1'b1;

    // Two-flop synchroniser for rx plus one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // UART receiver: start-bit recheck at half bit, then samples at bit centres
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            rx_ferr    <= 1'b0;
            rx_perr    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_s2 && rx_d) begin
                        rx_state <= R_START;
                        bit_cnt  <= '0;
                    end
                end
                R_START: begin
                    if (bit_cnt == 16'(CLKS_PER_BIT / 2 - 1)) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == 16'(CLKS_PER_BIT - 1)) begin
                        bit_cnt <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= (PARITY != 0) ? R_PAR : R_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                R_PAR: begin
                    if (bit_cnt == 16'(CLKS_PER_BIT - 1)) begin
                        bit_cnt  <= '0;
                        par_bit  <= rx_s2;
                        rx_state <= R_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (bit_cnt == 16'(CLKS_PER_BIT - 1)) begin
                        bit_cnt    <= '0;
                        byte_valid <= 1'b1;
                        rx_byte    <= shift;
                        rx_ferr    <= !rx_s2;
                        rx_perr    <= (PARITY != 0) && (par_bit != exp_par);
                        rx_state   <= R_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Frame parser and SRAM write engine; the engine's busy phase doubles as the one-byte buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_state   <= F_SYNC;
            wr_state  <= W_IDLE;
            len_idx   <= '0;
            length    <= '0;
            remaining <= '0;
            csum      <= '0;
            wdata     <= '0;
            drive     <= 1'b0;
            wcnt      <= '0;
            nce       <= 1'b1;
            nwe       <= 1'b1;
            addr      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (wr_state)
                W_SETUP: begin
                    nwe      <= 1'b0;
                    wcnt     <= '0;
                    wr_state <= W_PULSE;
                end
                W_PULSE: begin
                    if (wcnt == WCW'(WE_CYCLES - 1)) begin
                        nwe      <= 1'b1;
                        wr_state <= W_HOLD;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                W_HOLD: begin
                    nce      <= 1'b1;
                    drive    <= 1'b0;
                    addr     <= addr + ADDR_W'(1);
                    wr_state <= W_IDLE;
                end
                default: ;
            endcase

            if (byte_valid && !terminal) begin
                if (rx_ferr || rx_perr || busy) begin
                    f_state <= F_ERR;
                    err     <= 1'b1;
                end else begin
                    case (f_state)
                        F_SYNC: begin
                            if (rx_byte == 8'hA5) begin
                                f_state <= F_LEN;
                                len_idx <= '0;
                                length  <= '0;
                            end
                        end
                        F_LEN: begin
                            length  <= len_next;
                            len_idx <= len_idx + 4'd1;
                            if (len_idx == 4'(NB - 1)) begin
                                if ((len_next == '0) || ({1'b0, len_next} > MAX_LEN)) begin
                                    f_state <= F_ERR;
                                    err     <= 1'b1;
                                end else begin
                                    f_state   <= F_DATA;
                                    remaining <= len_next;
                                    csum      <= '0;
                                end
                            end
                        end
                        F_DATA: begin
                            nce       <= 1'b0;
                            drive     <= 1'b1;
                            wdata     <= rx_byte;
                            wr_state  <= W_SETUP;
                            csum      <= csum ^ rx_byte;
                            remaining <= remaining - LW'(1);
                            if (remaining == LW'(1)) begin
                                f_state <= F_CSUM;
                            end
                        end
                        F_CSUM: begin
                            if (rx_byte == csum) begin
                                f_state <= F_DONE;
                                done    <= 1'b1;
                            end else begin
                                f_state <= F_ERR;
                                err     <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_sram_loader.sv
// Testbench for uart_sram_loader: three instances (default, even parity,
// long write pulse), a behavioural SRAM monitor and a frame-level reference model.
module tb_uart_sram_loader;

    localparam int CPB  = 52;
    localparam int CPB2 = 16;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] rxv;

    wire  [7:0]  d0, d1, d2;
    logic        nce0, noe0, nwe0, done0, err0;
    logic        nce1, noe1, nwe1, done1, err1;
    logic        nce2, noe2, nwe2, done2, err2;
    logic [16:0] a0, a1, a2;

    int checks;
    int errors;

    int cyc;
    int nfall0, nfall1, nfall2;
    int nce_fall_cyc;
    int strobe_bad, noe_bad;
    bit in_wr, prev1, prev2;
    int cur_low, cur_addr;
    logic [7:0] cur_data;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_low_q[$];

    logic [7:0] frame_q[$];
    int exp_addr_q[$];
    int exp_data_q[$];
    bit exp_done, exp_err;
    int lat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (d0[g]);
        pullup (d1[g]);
        pullup (d2[g]);
    end

    uart_sram_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rxv[0]), .data_io(d0),
        .nce(nce0), .noe(noe0), .nwe(nwe0), .addr(a0), .done(done0), .err(err0)
    );

    uart_sram_loader #(.CLKS_PER_BIT(CPB2), .PARITY(1)) dutp (
        .clk(clk), .rst(rst), .rx(rxv[1]), .data_io(d1),
        .nce(nce1), .noe(noe1), .nwe(nwe1), .addr(a1), .done(done1), .err(err1)
    );

    uart_sram_loader #(.CLKS_PER_BIT(CPB2), .WE_CYCLES(600)) duto (
        .clk(clk), .rst(rst), .rx(rxv[2]), .data_io(d2),
        .nce(nce2), .noe(noe2), .nwe(nwe2), .addr(a2), .done(done2), .err(err2)
    );

    // SRAM-side monitor: records each write cycle and strobe violations on the falling clock edge
    initial begin
        cyc = 0; nfall0 = 0; nfall1 = 0; nfall2 = 0; nce_fall_cyc = -1;
        strobe_bad = 0; noe_bad = 0; in_wr = 0; prev1 = 1; prev2 = 1;
        cur_low = 0; cur_addr = 0; cur_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b1) begin
                in_wr = 0;
            end else begin
                if (!in_wr && nce0 === 1'b0) begin
                    in_wr = 1; cur_low = 0; cur_addr = int'(a0);
                    nce_fall_cyc = cyc; nfall0++;
                end
                if (in_wr && nce0 === 1'b0 && nwe0 === 1'b0) begin
                    cur_low++;
                    cur_data = d0;
                end
                if (in_wr && nce0 === 1'b1) begin
                    wr_addr_q.push_back(cur_addr);
                    wr_data_q.push_back(int'(cur_data));
                    wr_low_q.push_back(cur_low);
                    in_wr = 0;
                end
                if (nce1 === 1'b0 && prev1) nfall1++;
                if (nce2 === 1'b0 && prev2) nfall2++;
                if ((nce0 === 1'b1 && nwe0 === 1'b0) || (nce1 === 1'b1 && nwe1 === 1'b0) ||
                    (nce2 === 1'b1 && nwe2 === 1'b0)) strobe_bad++;
                if (noe0 !== 1'b1 || noe1 !== 1'b1 || noe2 !== 1'b1) noe_bad++;
            end
            prev1 = (nce1 === 1'b1);
            prev2 = (nce2 === 1'b1);
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #950000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic driveBit(input int which, input logic v);
        rxv[which] = v;
        repeat ((which == 0) ? CPB : CPB2) @(negedge clk);
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] b, input int par,
                                 input bit bad_stop, input bit bad_par);
        driveBit(which, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(which, b[i]);
        if (par != 0) driveBit(which, (^b) ^ (par == 2) ^ bad_par);
        driveBit(which, !bad_stop);
        rxv[which] = 1'b1;
        if (bad_stop) driveBit(which, 1'b1);
    endtask

    task automatic sendRange(input int which, input int par, input int lo, input int hi);
        for (int i = lo; i < hi; i++) applyStimulus(which, frame_q[i], par, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete(); wr_low_q.delete();
        nfall0 = 0; nfall1 = 0; nfall2 = 0; nce_fall_cyc = -1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: locate the sync byte, read the 3-byte length, XOR the payload
    task automatic modelFrame();
        int s, len, x, n;
        s = -1; x = 0; n = frame_q.size();
        exp_addr_q.delete(); exp_data_q.delete();
        exp_done = 0; exp_err = 0;
        for (int i = 0; i < n; i++) begin
            if (frame_q[i] == 8'hA5) begin s = i; break; end
        end
        if (s >= 0 && n >= s + 4) begin
            len = int'(frame_q[s+1]) | (int'(frame_q[s+2]) << 8) | (int'(frame_q[s+3]) << 16);
            if (len == 0 || len > (1 << 17)) begin
                exp_err = 1;
            end else begin
                for (int k = 0; k < len && (s + 4 + k) < n; k++) begin
                    exp_addr_q.push_back(k);
                    exp_data_q.push_back(int'(frame_q[s+4+k]));
                    x = x ^ int'(frame_q[s+4+k]);
                end
                if (s + 4 + len < n) begin
                    if (int'(frame_q[s+4+len]) == x) exp_done = 1;
                    else exp_err = 1;
                end
            end
        end
    endtask

    task automatic checkFrame(input string pre);
        int m;
        checkOutput({pre, "_wcount"}, wr_data_q.size(), exp_data_q.size());
        m = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
        for (int i = 0; i < m; i++) begin
            checkOutput({pre, "_waddr"}, wr_addr_q[i], exp_addr_q[i]);
            checkOutput({pre, "_wdata"}, wr_data_q[i], exp_data_q[i]);
            checkOutput({pre, "_nwe_low"}, wr_low_q[i], 2);
        end
        checkOutput({pre, "_done"}, done0, exp_done);
        checkOutput({pre, "_err"}, err0, exp_err);
    endtask

    task automatic runFrame(input string pre);
        doReset();
        modelFrame();
        sendRange(0, 0, 0, frame_q.size());
        repeat (2 * CPB) @(negedge clk);
        checkFrame(pre);
    endtask

    initial begin
        int t0, len, x;
        logic [7:0] b;
        checks = 0; errors = 0;
        rst = 1'b0; rxv = 3'b111;
        repeat (3) @(negedge clk);
        checkOutput("reset_nce", nce0, 1);
        checkOutput("reset_nwe", nwe0, 1);
        checkOutput("reset_noe", noe0, 1);
        checkOutput("reset_addr", a0, 0);
        checkOutput("reset_done", done0, 0);
        checkOutput("reset_err", err0, 0);
        checkOutput("reset_data_z", d0, 8'hFF);
        checkOutput("reset_nce_par", nce1, 1);
        checkOutput("reset_nce_ovr", nce2, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] nominal load");
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22, 8'h44, 8'h77};
        doReset();
        modelFrame();
        sendRange(0, 0, 0, 4);
        t0 = cyc;
        applyStimulus(0, frame_q[4], 0, 1'b0, 1'b0);
        lat = nce_fall_cyc - t0;
        sendRange(0, 0, 5, 8);
        repeat (2 * CPB) @(negedge clk);
        checkFrame("nominal");
        checkOutput("rx_latency_window", (lat >= 494 && lat <= 500), 1);

        $display("[TB] bad checksum");
        frame_q[7] = 8'h76;
        runFrame("badcsum");

        $display("[TB] framing error");
        doReset();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h11};
        sendRange(0, 0, 0, 5);
        applyStimulus(0, 8'h22, 0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("frame_err_flag", err0, 1);
        applyStimulus(0, 8'h44, 0, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checkOutput("frame_err_writes", nfall0, 1);
        checkOutput("frame_err_done", done0, 0);

        $display("[TB] noise before sync");
        frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22, 8'h44, 8'h77};
        doReset();
        modelFrame();
        sendRange(0, 0, 0, 3);
        rxv[0] = 1'b0;
        repeat (10) @(negedge clk);
        rxv[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        sendRange(0, 0, 3, frame_q.size());
        repeat (2 * CPB) @(negedge clk);
        checkFrame("noise");

        $display("[TB] length limits");
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h02};
        runFrame("len_big");
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        runFrame("len_zero");

        $display("[TB] reset mid-write");
        doReset();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00};
        sendRange(0, 0, 0, 4);
        b = 8'h11;
        driveBit(0, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(0, b[i]);
        rxv[0] = 1'b1;
        for (int i = 0; i < 2 * CPB; i++) begin
            if (nwe0 === 1'b0) break;
            @(negedge clk);
        end
        checkOutput("rstmid_nwe_seen", nwe0, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstmid_nce", nce0, 1);
        checkOutput("rstmid_nwe", nwe0, 1);
        checkOutput("rstmid_data_z", d0, 8'hFF);
        checkOutput("rstmid_addr", a0, 0);
        repeat (CPB) @(negedge clk);
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22, 8'h44, 8'h77};
        runFrame("fresh");

        $display("[TB] even parity instance");
        doReset();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h33, 8'h44, 8'h77};
        sendRange(1, 1, 0, 7);
        repeat (2 * CPB2) @(negedge clk);
        checkOutput("par_ok_done", done1, 1);
        checkOutput("par_ok_err", err1, 0);
        checkOutput("par_ok_writes", nfall1, 2);
        checkOutput("par_ok_addr", a1, 2);
        doReset();
        sendRange(1, 1, 0, 4);
        applyStimulus(1, 8'h33, 1, 1'b0, 1'b1);
        repeat (2 * CPB2) @(negedge clk);
        checkOutput("par_bad_err", err1, 1);
        checkOutput("par_bad_done", done1, 0);
        checkOutput("par_bad_writes", nfall1, 0);

        $display("[TB] overrun instance");
        doReset();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        sendRange(2, 0, 0, 5);
        checkOutput("ovr_first_err", err2, 0);
        applyStimulus(2, 8'h22, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("ovr_second_err", err2, 1);
        checkOutput("ovr_done", done2, 0);
        repeat (700) @(negedge clk);
        checkOutput("ovr_writes", nfall2, 1);
        checkOutput("ovr_nce_idle", nce2, 1);
        checkOutput("ovr_addr", a2, 1);
        checkOutput("ovr_data_z", d2, 8'hFF);
        checkOutput("par_data_z", d1, 8'hFF);

        $display("[TB] randomized frames");
        for (int r = 0; r < 3; r++) begin
            frame_q.delete();
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                frame_q.push_back(b);
            end
            len = $urandom_range(1, 4);
            frame_q.push_back(8'hA5);
            frame_q.push_back(8'(len));
            frame_q.push_back(8'h00);
            frame_q.push_back(8'h00);
            x = 0;
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom_range(0, 255));
                frame_q.push_back(b);
                x = x ^ int'(b);
            end
            if ($urandom_range(0, 1) == 1) x = x ^ $urandom_range(1, 255);
            frame_q.push_back(8'(x));
            runFrame("random");
        end

        checkOutput("strobe_order", strobe_bad, 0);
        checkOutput("noe_constant", noe_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
